// File: rtl/cv32e40p_x_if_pkg.sv
// Shared types and helpers for the eXtension interface and its Xmem-to-OBI bridge.
package cv32e40p_x_if_pkg;

  typedef enum logic [0:0] {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_req_type_e;

  // Xmem access size encodings; 3..7 are illegal
  localparam logic [2:0] XMEM_BYTE = 3'd0;
  localparam logic [2:0] XMEM_HALF = 3'd1;
  localparam logic [2:0] XMEM_WORD = 3'd2;

  localparam logic XMEM_STATUS_OK  = 1'b0;
  localparam logic XMEM_STATUS_ERR = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StRvalid,
    StResp
  } xmem_obi_state_e;

  function automatic logic xmem_width_legal(input logic [2:0] width);
    return (width == XMEM_BYTE) || (width == XMEM_HALF) || (width == XMEM_WORD);
  endfunction

  function automatic logic xmem_misaligned(input logic [2:0] width, input logic [1:0] addr_lo);
    return ((width == XMEM_HALF) && addr_lo[0]) || ((width == XMEM_WORD) && (addr_lo != 2'b00));
  endfunction

  // Index of the last valid data bit for a legal width, 0 otherwise
  function automatic logic [5:0] xmem_range(input logic [2:0] width);
    case (width)
      XMEM_BYTE: return 6'd7;
      XMEM_HALF: return 6'd15;
      XMEM_WORD: return 6'd31;
      default:   return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/cv32e40p_xmem_lsu_align.sv
// Combinational byte-lane alignment: byte enables, write-data lane shift and
// read-data LSB alignment with zero extension to the access width.
module cv32e40p_xmem_lsu_align
  import cv32e40p_x_if_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  width_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  shamt;
  logic [31:0] rdata_mask;

  assign shamt = {addr_lo_i, 3'b000};

  // Decode enables and read mask from size; enables past lane 3 fall off the top
  always_comb begin
    be_o       = 4'b0000;
    rdata_mask = 32'h0000_0000;
    case (width_i)
      XMEM_BYTE: begin
        be_o       = 4'b0001 << addr_lo_i;
        rdata_mask = 32'h0000_00ff;
      end
      XMEM_HALF: begin
        be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
        rdata_mask = 32'h0000_ffff;
      end
      XMEM_WORD: begin
        be_o       = 4'b1111;
        rdata_mask = 32'hffff_ffff;
      end
      default: ;
    endcase
    wdata_o = wdata_i << shamt;
    rdata_o = (rdata_i >> shamt) & rdata_mask;
  end

endmodule

// File: rtl/cv32e40p_xmem_obi_bridge.sv
// Bridges single Xmem requests onto an OBI data port, one transaction at a time.
// Optional feature: define XMEM_OBI_MISALIGN_CHECK_EN to reject misaligned
// half/word accesses locally instead of issuing them on OBI.
module cv32e40p_xmem_obi_bridge
  import cv32e40p_x_if_pkg::*;
#(
  parameter int unsigned RANGE_W             = 5,
  parameter logic        MISALIGN_ERR_STATUS = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               xmem_q_valid_i,
  output logic               xmem_q_ready_o,
  input  logic [31:0]        xmem_q_laddr_i,
  input  logic [31:0]        xmem_q_wdata_i,
  input  logic [2:0]         xmem_q_width_i,
  input  mem_req_type_e      xmem_q_req_type_i,
  input  logic               xmem_q_mode_i,
  input  logic               xmem_q_spec_i,
  input  logic               xmem_q_endoftransaction_i,
  output logic               xmem_p_valid_o,
  input  logic               xmem_p_ready_i,
  output logic [31:0]        xmem_p_rdata_o,
  output logic [RANGE_W-1:0] xmem_p_range_o,
  output logic               xmem_p_status_o,
  output logic               data_req_o,
  input  logic               data_gnt_i,
  output logic [31:0]        data_addr_o,
  output logic               data_we_o,
  output logic [3:0]         data_be_o,
  output logic [31:0]        data_wdata_o,
  input  logic               data_rvalid_i,
  input  logic [31:0]        data_rdata_i,
  input  logic               data_err_i
);

  xmem_obi_state_e    state_q;
  logic               ready_q, req_q, p_valid_q;
  logic [31:0]        addr_q, wdata_q, rdata_q;
  logic [2:0]         width_q;
  logic               we_q, status_q;
  logic [RANGE_W-1:0] range_q;

  logic               q_reject;
  logic [3:0]         be_lane;
  logic [31:0]        wdata_lane, rdata_lsb;
  logic               unused_q_hints;

  assign unused_q_hints = xmem_q_mode_i ^ xmem_q_spec_i ^ xmem_q_endoftransaction_i;

  // Decide whether an incoming request must be answered locally with an error
  always_comb begin
`ifdef XMEM_OBI_MISALIGN_CHECK_EN
    q_reject = !xmem_width_legal(xmem_q_width_i) ||
               xmem_misaligned(xmem_q_width_i, xmem_q_laddr_i[1:0]);
`else
    q_reject = !xmem_width_legal(xmem_q_width_i);
`endif
  end

  cv32e40p_xmem_lsu_align u_align (
    .addr_lo_i (addr_q[1:0]),
    .width_i   (width_q),
    .wdata_i   (wdata_q),
    .rdata_i   (data_rdata_i),
    .be_o      (be_lane),
    .wdata_o   (wdata_lane),
    .rdata_o   (rdata_lsb)
  );

  // Transaction FSM with registered handshake outputs and response register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ready_q   <= 1'b0;
      req_q     <= 1'b0;
      p_valid_q <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      width_q   <= 3'd0;
      we_q      <= 1'b0;
      rdata_q   <= 32'h0;
      status_q  <= 1'b0;
      range_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (xmem_q_valid_i && ready_q) begin
            ready_q <= 1'b0;
            addr_q  <= xmem_q_laddr_i;
            wdata_q <= xmem_q_wdata_i;
            width_q <= xmem_q_width_i;
            we_q    <= (xmem_q_req_type_i == WRITE);
            if (q_reject) begin
              state_q   <= StResp;
              p_valid_q <= 1'b1;
              status_q  <= MISALIGN_ERR_STATUS;
              rdata_q   <= 32'h0;
              range_q   <= '0;
            end else begin
              state_q <= StAddr;
              req_q   <= 1'b1;
            end
          end
        end
        StAddr: begin
          if (data_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= StRvalid;
          end
        end
        StRvalid: begin
          if (data_rvalid_i) begin
            rdata_q   <= we_q ? 32'h0 : rdata_lsb;
            status_q  <= data_err_i;
            range_q   <= RANGE_W'(xmem_range(width_q));
            p_valid_q <= 1'b1;
            state_q   <= StResp;
          end
        end
        StResp: begin
          if (xmem_p_ready_i) begin
            p_valid_q <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign xmem_q_ready_o  = ready_q;
  assign xmem_p_valid_o  = p_valid_q;
  assign xmem_p_rdata_o  = rdata_q;
  assign xmem_p_range_o  = range_q;
  assign xmem_p_status_o = status_q;
  assign data_req_o      = req_q;
  assign data_addr_o     = {addr_q[31:2], 2'b00};
  assign data_we_o       = we_q & req_q;
  assign data_be_o       = req_q ? be_lane : 4'b0000;
  assign data_wdata_o    = req_q ? wdata_lane : 32'h0;

endmodule

// File: tb/tb_cv32e40p_xmem_obi_bridge.sv
// Directed self-checking bench for the Xmem-to-OBI bridge.
module tb_cv32e40p_xmem_obi_bridge;
  import cv32e40p_x_if_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          q_valid, q_ready;
  logic [31:0]   q_laddr, q_wdata;
  logic [2:0]    q_width;
  mem_req_type_e q_type;
  logic          p_valid, p_ready;
  logic [31:0]   p_rdata;
  logic [4:0]    p_range;
  logic          p_status;
  logic          req, gnt, we, rvalid, err;
  logic [31:0]   addr, wdata, rdata;
  logic [3:0]    be;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cv32e40p_xmem_obi_bridge #(
    .RANGE_W             (5),
    .MISALIGN_ERR_STATUS (1'b1)
  ) dut (
    .clk_i                     (clk),
    .rst_ni                    (rst_n),
    .xmem_q_valid_i            (q_valid),
    .xmem_q_ready_o            (q_ready),
    .xmem_q_laddr_i            (q_laddr),
    .xmem_q_wdata_i            (q_wdata),
    .xmem_q_width_i            (q_width),
    .xmem_q_req_type_i         (q_type),
    .xmem_q_mode_i             (1'b0),
    .xmem_q_spec_i             (1'b0),
    .xmem_q_endoftransaction_i (1'b1),
    .xmem_p_valid_o            (p_valid),
    .xmem_p_ready_i            (p_ready),
    .xmem_p_rdata_o            (p_rdata),
    .xmem_p_range_o            (p_range),
    .xmem_p_status_o           (p_status),
    .data_req_o                (req),
    .data_gnt_i                (gnt),
    .data_addr_o               (addr),
    .data_we_o                 (we),
    .data_be_o                 (be),
    .data_wdata_o              (wdata),
    .data_rvalid_i             (rvalid),
    .data_rdata_i              (rdata),
    .data_err_i                (err)
  );

  // Present a request for one cycle (cycle 0); caller is at a negedge
  task automatic issue(input logic [31:0] a, input logic [2:0] w, input mem_req_type_e t,
                       input logic [31:0] d);
    q_valid = 1'b1; q_laddr = a; q_width = w; q_type = t; q_wdata = d;
    @(negedge clk);
    q_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (q_ready !== 1'b0) begin n_fail++; $display("FAIL rst_q_ready got %b exp 0", q_ready); end
    n_tests++; if ({req, we, be, addr, wdata} !== '0) begin n_fail++;
      $display("FAIL rst_obi got req=%b we=%b be=%h addr=%h wd=%h exp 0", req, we, be, addr, wdata); end
    n_tests++; if ({p_valid, p_rdata, p_range, p_status} !== '0) begin n_fail++;
      $display("FAIL rst_resp got v=%b rd=%h rg=%0d st=%b exp 0", p_valid, p_rdata, p_range, p_status); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (q_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %b exp 1", q_ready); end
  endtask

  task automatic test_word_read();
    issue(32'h100, XMEM_WORD, READ, 32'h0);
    n_tests++; if ({req, be, we, addr} !== {1'b1, 4'hF, 1'b0, 32'h100}) begin n_fail++;
      $display("FAIL wrd_addr got req=%b be=%h we=%b addr=%h exp 1 f 0 00000100", req, be, we, addr); end
    n_tests++; if (q_ready !== 1'b0) begin n_fail++; $display("FAIL wrd_busy got %b exp 0", q_ready); end
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    n_tests++; if ({req, p_valid} !== 2'b00) begin n_fail++;
      $display("FAIL wrd_c2 got req=%b pv=%b exp 00", req, p_valid); end
    rvalid = 1'b1; rdata = 32'hDEADBEEF;
    @(negedge clk);
    rvalid = 1'b0;
    n_tests++; if ({p_valid, p_rdata, p_range, p_status} !== {1'b1, 32'hDEADBEEF, 5'd31, 1'b0}) begin
      n_fail++; $display("FAIL wrd_resp got v=%b rd=%h rg=%0d st=%b exp 1 deadbeef 31 0",
                         p_valid, p_rdata, p_range, p_status); end
    p_ready = 1'b1;
    @(negedge clk);
    p_ready = 1'b0;
    n_tests++; if ({p_valid, q_ready} !== 2'b01) begin n_fail++;
      $display("FAIL wrd_done got pv=%b qr=%b exp 01", p_valid, q_ready); end
  endtask

  task automatic test_byte_write();
    issue(32'h103, XMEM_BYTE, WRITE, 32'h0000_00A5);
    n_tests++; if ({req, we, be, addr, wdata} !== {1'b1, 1'b1, 4'b1000, 32'h100, 32'hA500_0000}) begin
      n_fail++; $display("FAIL bw_addr got req=%b we=%b be=%b addr=%h wd=%h exp 1 1 1000 00000100 a5000000",
                         req, we, be, addr, wdata); end
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'hFFFF_FFFF; err = 1'b0;
    @(negedge clk);
    rvalid = 1'b0;
    n_tests++; if ({p_valid, p_rdata, p_range, p_status} !== {1'b1, 32'h0, 5'd7, 1'b0}) begin
      n_fail++; $display("FAIL bw_resp got v=%b rd=%h rg=%0d st=%b exp 1 0 7 0",
                         p_valid, p_rdata, p_range, p_status); end
    p_ready = 1'b1;
    @(negedge clk);
    p_ready = 1'b0;
  endtask

  task automatic test_write_err();
    issue(32'h204, XMEM_WORD, WRITE, 32'hCAFE_F00D);
    n_tests++; if ({we, be, addr, wdata} !== {1'b1, 4'hF, 32'h204, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL we_addr got we=%b be=%h addr=%h wd=%h exp 1 f 00000204 cafef00d",
                         we, be, addr, wdata); end
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; err = 1'b1;
    @(negedge clk);
    rvalid = 1'b0; err = 1'b0;
    n_tests++; if ({p_valid, p_rdata, p_status} !== {1'b1, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL we_resp got v=%b rd=%h st=%b exp 1 0 1", p_valid, p_rdata, p_status); end
    p_ready = 1'b1;
    @(negedge clk);
    p_ready = 1'b0;
  endtask

  task automatic test_half_read_delayed();
    issue(32'h202, XMEM_HALF, READ, 32'h0);
    for (int i = 0; i < 4; i++) begin
      n_tests++; if ({req, be, we, addr} !== {1'b1, 4'b1100, 1'b0, 32'h200}) begin n_fail++;
        $display("FAIL hr_hold%0d got req=%b be=%b we=%b addr=%h exp 1 1100 0 00000200",
                 i, req, be, we, addr); end
      // A stray rvalid during the address phase must be ignored
      rvalid = (i == 1); rdata = 32'hBAD0_BAD0;
      gnt = (i == 3);
      @(negedge clk);
    end
    gnt = 1'b0;
    n_tests++; if ({req, p_valid} !== 2'b00) begin n_fail++;
      $display("FAIL hr_c5 got req=%b pv=%b exp 00", req, p_valid); end
    rvalid = 1'b1; rdata = 32'h1234_ABCD;
    @(negedge clk);
    rvalid = 1'b0;
    n_tests++; if ({p_valid, p_rdata, p_range, p_status} !== {1'b1, 32'h0000_1234, 5'd15, 1'b0}) begin
      n_fail++; $display("FAIL hr_resp got v=%b rd=%h rg=%0d st=%b exp 1 00001234 15 0",
                         p_valid, p_rdata, p_range, p_status); end
    p_ready = 1'b1;
    @(negedge clk);
    p_ready = 1'b0;
  endtask

  task automatic test_illegal_width();
    q_valid = 1'b1; q_laddr = 32'h400; q_width = 3'd3; q_type = READ; q_wdata = 32'h0;
    @(negedge clk);
    // Second request stays pending while the error response is held
    q_width = XMEM_WORD;
    n_tests++; if ({p_valid, p_status, p_rdata, p_range, req} !== {1'b1, 1'b1, 32'h0, 5'd0, 1'b0}) begin
      n_fail++; $display("FAIL il_resp got v=%b st=%b rd=%h rg=%0d req=%b exp 1 1 0 0 0",
                         p_valid, p_status, p_rdata, p_range, req); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if ({q_ready, req, p_valid} !== 3'b001) begin n_fail++;
        $display("FAIL il_stall%0d got qr=%b req=%b pv=%b exp 001", i, q_ready, req, p_valid); end
    end
    q_valid = 1'b0; p_ready = 1'b1;
    @(negedge clk);
    p_ready = 1'b0;
    n_tests++; if ({p_valid, req, q_ready} !== 3'b001) begin n_fail++;
      $display("FAIL il_done got pv=%b req=%b qr=%b exp 001", p_valid, req, q_ready); end
  endtask

  task automatic test_misalign();
    issue(32'h101, XMEM_WORD, READ, 32'h0);
`ifdef XMEM_OBI_MISALIGN_CHECK_EN
    n_tests++; if ({p_valid, p_status, p_rdata, req} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin n_fail++;
      $display("FAIL ma_reject got v=%b st=%b rd=%h req=%b exp 1 1 0 0", p_valid, p_status, p_rdata, req);
    end
`else
    n_tests++; if ({req, be, addr} !== {1'b1, 4'hF, 32'h100}) begin n_fail++;
      $display("FAIL ma_addr got req=%b be=%h addr=%h exp 1 f 00000100", req, be, addr); end
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1122_3344;
    @(negedge clk);
    rvalid = 1'b0;
    n_tests++; if ({p_valid, p_rdata, p_status} !== {1'b1, 32'h0011_2233, 1'b0}) begin n_fail++;
      $display("FAIL ma_resp got v=%b rd=%h st=%b exp 1 00112233 0", p_valid, p_rdata, p_status); end
`endif
    p_ready = 1'b1;
    @(negedge clk);
    p_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    issue(32'h300, XMEM_WORD, WRITE, 32'h5555_AAAA);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    // Now waiting for rvalid; reset must clear outputs without a clock edge
    rst_n = 1'b0;
    #1;
    n_tests++; if ({req, we, be, addr, wdata, q_ready, p_valid, p_rdata, p_range, p_status} !== '0) begin
      n_fail++; $display("FAIL rm_async got addr=%h req=%b pv=%b qr=%b exp all 0", addr, req, p_valid, q_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0055; err = 1'b1;
    @(negedge clk);
    rvalid = 1'b0; err = 1'b0;
    n_tests++; if ({p_valid, q_ready, req} !== 3'b010) begin n_fail++;
      $display("FAIL rm_late got pv=%b qr=%b req=%b exp 010", p_valid, q_ready, req); end
    issue(32'h301, XMEM_BYTE, READ, 32'h0);
    n_tests++; if ({req, be, addr} !== {1'b1, 4'b0010, 32'h300}) begin n_fail++;
      $display("FAIL rm_next_addr got req=%b be=%b addr=%h exp 1 0010 00000300", req, be, addr); end
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'hAABB_CCDD;
    @(negedge clk);
    rvalid = 1'b0;
    n_tests++; if ({p_valid, p_rdata, p_range, p_status} !== {1'b1, 32'h0000_00CC, 5'd7, 1'b0}) begin
      n_fail++; $display("FAIL rm_next_resp got v=%b rd=%h rg=%0d st=%b exp 1 000000cc 7 0",
                         p_valid, p_rdata, p_range, p_status); end
    p_ready = 1'b1;
    @(negedge clk);
    p_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; q_valid = 1'b0; q_laddr = '0; q_wdata = '0; q_width = '0; q_type = READ;
    p_ready = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; err = 1'b0;
    test_reset();
    test_word_read();
    test_byte_write();
    test_write_err();
    test_half_read_delayed();
    test_illegal_width();
    test_misalign();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_xmem_obi_bridge.md
CV32E40P_XMEM_OBI_BRIDGE -- requirements
Module: cv32e40p_xmem_obi_bridge

Interface
REQ-001 SHALL have parameter RANGE_W, default 5, giving the width of xmem_p_range_o.
REQ-002 SHALL have parameter MISALIGN_ERR_STATUS, default 1'b1, giving the status value returned for rejected requests.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 xmem_q_valid_i / xmem_q_ready_o  in/out  1/1  Xmem request handshake from the accelerator adapter.
REQ-006 xmem_q_laddr_i  in  32  byte address.
REQ-007 xmem_q_wdata_i  in  32  write data, LSB-aligned.
REQ-008 xmem_q_width_i  in  3  access size: 0 byte, 1 half, 2 word; 3-7 illegal.
REQ-009 xmem_q_req_type_i  in  mem_req_type_e  read or write.
REQ-010 xmem_q_mode_i, xmem_q_spec_i, xmem_q_endoftransaction_i  in  1 each  accepted and ignored.
REQ-011 xmem_p_valid_o / xmem_p_ready_i  out/in  1/1  Xmem response handshake.
REQ-012 xmem_p_rdata_o  out  32  read data, LSB-aligned and zero-extended.
REQ-013 xmem_p_range_o  out  RANGE_W  index of the last valid bit: 7, 15 or 31.
REQ-014 xmem_p_status_o  out  1  0 ok, 1 error.
REQ-015 data_req_o / data_gnt_i  out/in  1/1  OBI address phase.
REQ-016 data_addr_o  out  32  word-aligned address.
REQ-017 data_we_o  out  1  write enable.
REQ-018 data_be_o  out  4  byte enables.
REQ-019 data_wdata_o  out  32  lane-aligned write data.
REQ-020 data_rvalid_i, data_rdata_i, data_err_i  in  1/32/1  OBI response phase.

Function
REQ-021 SHALL implement the FSM IDLE -> ADDR -> RVALID -> RESP -> IDLE, with exactly one transaction outstanding.
REQ-022 xmem_q_ready_o SHALL be 1 only in IDLE; on q_valid&&q_ready the block SHALL register all request fields and move to ADDR.
REQ-023 In ADDR, data_req_o SHALL be 1 with stable address, we, be and wdata until data_gnt_i; then the block SHALL move to RVALID.
REQ-024 data_req_o SHALL NOT deassert before data_gnt_i.
REQ-025 In RVALID, on data_rvalid_i the block SHALL capture the aligned rdata and data_err_i into the response register and move to RESP.
REQ-026 In RESP, xmem_p_valid_o SHALL be 1 with stable outputs until xmem_p_ready_i; then the block SHALL return to IDLE.
REQ-027 Minimum latency SHALL be: accept cycle 0, req cycle 1, gnt cycle 1, rvalid cycle 2, p_valid cycle 3.
REQ-028 A gnt arriving in the same cycle req rises SHALL count as granted; an rvalid arriving in any other state SHALL be ignored.
REQ-029 Byte enables SHALL be: byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'b1111.
REQ-030 wdata SHALL be shifted left by 8*a[1:0].
REQ-031 rdata SHALL be shifted right by 8*a[1:0] and masked to the access width.
REQ-032 range SHALL be (8<<width)-1.
REQ-033 Write responses SHALL return rdata=0 and status=data_err_i.
REQ-034 An illegal width SHALL bypass OBI: the block SHALL go IDLE -> RESP with status=MISALIGN_ERR_STATUS, rdata=0 and range=0.
REQ-035 data_addr_o SHALL be {laddr[31:2],2'b00}.

Reset
REQ-036 Asserting rst_ni low SHALL force IDLE asynchronously, at any state including mid-transaction.
REQ-037 Under reset, all outputs SHALL be 0 and xmem_q_ready_o SHALL go to 1 after release.
REQ-038 An OBI transaction in flight at reset SHALL be abandoned.

Configuration
REQ-039 With XMEM_OBI_MISALIGN_CHECK_EN defined, a half access with a[0]=1, or a word access with a[1:0]!=0, SHALL be rejected as in REQ-034 without any OBI access.
REQ-040 Without XMEM_OBI_MISALIGN_CHECK_EN, such accesses SHALL be issued with the REQ-029 enables, truncated to 4 bits, with no split access.

Structure
REQ-041 Width encodings (XMEM_BYTE/HALF/WORD), status constants and the FSM state enum SHALL be added to cv32e40p_x_if_pkg, next to mem_req_type_e.
REQ-042 Byte-enable, write-data and read-data alignment SHALL be a combinational sub-module, cv32e40p_xmem_lsu_align.

Verification
REQ-043 Word read at 0x100 with gnt and rvalid immediate, rdata=0xDEADBEEF -> be=4'hF, p_valid at cycle 3, rdata=0xDEADBEEF, range=31, status=0.
REQ-044 Byte write at 0x103 with wdata=0xA5 -> be=4'b1000, data_wdata[31:24]=0xA5, we=1, response status=0, rdata=0.
REQ-045 Half read at 0x202 with gnt delayed 3 cycles and rdata=0x1234ABCD -> req held stable for 4 cycles, rdata=0x00001234, range=15.
REQ-046 width=3 -> no data_req_o ever, p_valid at cycle 1 with status=1; a second request while p_ready=0 -> q_ready stays 0.
REQ-047 Word read at 0x101 with the macro on -> status=1 and no OBI access; with the macro off -> data_addr=0x100.
REQ-048 Reset pulse in RVALID -> all outputs 0 at once; a late rvalid after release is ignored; the next request completes normally.
